hyperbus_reg_async_src: RTL and testbench



---
 rtl/hyperbus_pkg.sv | 79 +++++++
 rtl/hyperbus_reg_async_src_if.sv | 57 +++++
 rtl/hyperbus_sync.sv | 32 +++
 rtl/hyperbus_reg_async_src.sv | 141 ++++++++++++++
 tb/tb_hyperbus_reg_async_src.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hyperbus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hyperbus_pkg
//  Brief    : Shared definitions for the HyperBus register-bus clock-domain
//             crossing. Holds the source-side FSM states and the packing and
//             unpacking helpers for the request and response payloads, so the
//             sink side can use the same bit layout.
//  Revision : 1.0 - initial release
// ============================================================================
package hyperbus_pkg;

  // Source-side crossing FSM states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ_HI   = 3'd1,
    ST_REQ_LO   = 3'd2,
    ST_RSP_WAIT = 3'd3,
    ST_RSP_LO   = 3'd4
  } reg_src_state_e;

  // Default register-bus geometry shared by both ends of the crossing.
  localparam int unsigned REG_AW    = 32;
  localparam int unsigned REG_DW    = 32;
  localparam int unsigned REG_SW    = REG_DW / 8;
  localparam int unsigned REG_REQ_W = REG_AW + 1 + REG_DW + REG_SW + 1;
  localparam int unsigned REG_RSP_W = REG_DW + 2;

  // Request payload, MSB first: {addr, write, wdata, wstrb, valid}.
  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic              write;
    logic [REG_DW-1:0] wdata;
    logic [REG_SW-1:0] wstrb;
    logic              valid;
  } reg_req_t;

  // Response payload, MSB first: {rdata, error, ready}.
  typedef struct packed {
    logic [REG_DW-1:0] rdata;
    logic              error;
    logic              ready;
  } reg_rsp_t;

  function automatic logic [REG_REQ_W-1:0] pack_req(
    input logic [REG_AW-1:0] addr,
    input logic              write,
    input logic [REG_DW-1:0] wdata,
    input logic [REG_SW-1:0] wstrb
  );
    reg_req_t req;
    req.addr  = addr;
    req.write = write;
    req.wdata = wdata;
    req.wstrb = wstrb;
    req.valid = 1'b1;
    return req;
  endfunction

  function automatic reg_req_t unpack_req(input logic [REG_REQ_W-1:0] data);
    return reg_req_t'(data);
  endfunction

  function automatic logic [REG_RSP_W-1:0] pack_rsp(
    input logic [REG_DW-1:0] rdata,
    input logic              error
  );
    reg_rsp_t rsp;
    rsp.rdata = rdata;
    rsp.error = error;
    rsp.ready = 1'b1;
    return rsp;
  endfunction

  function automatic reg_rsp_t unpack_rsp(input logic [REG_RSP_W-1:0] data);
    return reg_rsp_t'(data);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hyperbus_reg_async_src_if.sv
`default_nettype none
// ============================================================================
//  Module   : hyperbus_reg_async_src_if
//  Brief    : Register-bus and four-phase asynchronous channel signals of the
//             HyperBus register crossing source. The slave modport is the
//             crossing's own view; the master modport is its environment
//             (SoC requester plus HyperBus-side peer).
//  Revision : 1.0 - initial release
// ============================================================================
interface hyperbus_reg_async_src_if #(
  parameter int unsigned RegAddrWidth = 32,
  parameter int unsigned RegDataWidth = 32
);
  localparam int unsigned RegStrbWidth = RegDataWidth / 8;
  localparam int unsigned RegReqWidth  = RegAddrWidth + 1 + RegDataWidth + RegStrbWidth + 1;
  localparam int unsigned RegRspWidth  = RegDataWidth + 2;

  // SoC register bus
  logic                    reg_valid_i;
  logic                    reg_write_i;
  logic [RegAddrWidth-1:0] reg_addr_i;
  logic [RegDataWidth-1:0] reg_wdata_i;
  logic [RegStrbWidth-1:0] reg_wstrb_i;
  logic                    reg_ready_o;
  logic [RegDataWidth-1:0] reg_rdata_o;
  logic                    reg_error_o;

  // Asynchronous request channel
  logic                    async_reg_req_req_o;
  logic                    async_reg_req_ack_i;
  logic [RegReqWidth-1:0]  async_reg_req_data_o;

  // Asynchronous response channel
  logic                    async_reg_rsp_req_i;
  logic                    async_reg_rsp_ack_o;
  logic [RegRspWidth-1:0]  async_reg_rsp_data_i;

  modport slave (
    input  reg_valid_i, reg_write_i, reg_addr_i, reg_wdata_i, reg_wstrb_i,
    output reg_ready_o, reg_rdata_o, reg_error_o,
    output async_reg_req_req_o, async_reg_req_data_o,
    input  async_reg_req_ack_i,
    input  async_reg_rsp_req_i, async_reg_rsp_data_i,
    output async_reg_rsp_ack_o
  );

  modport master (
    output reg_valid_i, reg_write_i, reg_addr_i, reg_wdata_i, reg_wstrb_i,
    input  reg_ready_o, reg_rdata_o, reg_error_o,
    input  async_reg_req_req_o, async_reg_req_data_o,
    output async_reg_req_ack_i,
    output async_reg_rsp_req_i, async_reg_rsp_data_i,
    input  async_reg_rsp_ack_o
  );

endinterface
`default_nettype wire

// File: rtl/hyperbus_sync.sv
`default_nettype none
// ============================================================================
//  Module   : hyperbus_sync
//  Brief    : SyncStages-deep flip-flop synchronizer for a single-bit level
//             arriving from the HyperBus clock domain. SyncStages must be 2 or
//             more.
//  Revision : 1.0 - initial release
// ============================================================================
module hyperbus_sync #(
  parameter int unsigned SyncStages = 3
) (
  input  logic clk_sys_i,
  input  logic rst_sys_ni,
  input  logic i_d,
  output logic o_q
);

  logic [SyncStages-1:0] r_chain;

  // Shift the asynchronous level through the chain; the last stage is safe to use.
  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_ni) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SyncStages-2:0], i_d};
    end
  end

  assign o_q = r_chain[SyncStages-1];

endmodule
`default_nettype wire

// File: rtl/hyperbus_reg_async_src.sv
`default_nettype none
// ============================================================================
//  Module   : hyperbus_reg_async_src
//  Brief    : SoC-side source of the HyperBus register-bus crossing. Takes one
//             register request at a time, runs it through a four-phase
//             request handshake, then waits for the four-phase response and
//             returns read data / error with a single-cycle ready pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module hyperbus_reg_async_src
  import hyperbus_pkg::*;
#(
  parameter int unsigned RegAddrWidth = 32,
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned SyncStages   = 3
) (
  input  logic                   clk_sys_i,
  input  logic                   rst_sys_ni,
  hyperbus_reg_async_src_if.slave bus
);

  localparam int unsigned RegStrbWidth = RegDataWidth / 8;
  localparam int unsigned RegReqWidth  = RegAddrWidth + 1 + RegDataWidth + RegStrbWidth + 1;
  localparam int unsigned RegRspWidth  = RegDataWidth + 2;

  localparam logic [2:0] S_IDLE     = ST_IDLE;
  localparam logic [2:0] S_REQ_HI   = ST_REQ_HI;
  localparam logic [2:0] S_REQ_LO   = ST_REQ_LO;
  localparam logic [2:0] S_RSP_WAIT = ST_RSP_WAIT;
  localparam logic [2:0] S_RSP_LO   = ST_RSP_LO;

  logic                    w_ack_s;
  logic                    w_rreq_s;
  logic [RegReqWidth-1:0]  w_req_pack;
  logic [RegDataWidth-1:0] w_rsp_rdata;
  logic                    w_rsp_error;
  logic                    w_rsp_ready_unused;

  logic [2:0]              r_state;
  logic                    r_req;
  logic                    r_rsp_ack;
  logic                    r_ready;
  logic                    r_error;
  logic [RegDataWidth-1:0] r_rdata;
  logic [RegReqWidth-1:0]  r_req_data;

  hyperbus_sync #(.SyncStages(SyncStages)) u_sync_ack (
    .clk_sys_i  (clk_sys_i),
    .rst_sys_ni (rst_sys_ni),
    .i_d        (bus.async_reg_req_ack_i),
    .o_q        (w_ack_s)
  );

  hyperbus_sync #(.SyncStages(SyncStages)) u_sync_rreq (
    .clk_sys_i  (clk_sys_i),
    .rst_sys_ni (rst_sys_ni),
    .i_d        (bus.async_reg_rsp_req_i),
    .o_q        (w_rreq_s)
  );

  // Request payload, MSB first; the valid bit is always set on the wire.
  assign w_req_pack = {bus.reg_addr_i, bus.reg_write_i, bus.reg_wdata_i,
                       bus.reg_wstrb_i, 1'b1};

  // Response data is not synchronized: it is only consumed while the
  // synchronized response req is high, when the peer keeps it stable.
  // The payload ready bit is redundant with the handshake and is dropped.
  assign w_rsp_rdata        = bus.async_reg_rsp_data_i[RegRspWidth-1 -: RegDataWidth];
  assign w_rsp_error        = bus.async_reg_rsp_data_i[1];
  assign w_rsp_ready_unused = bus.async_reg_rsp_data_i[0];

  // Sequence one transaction: request four-phase cycle, then response four-phase cycle.
  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_ni) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_rsp_ack  <= 1'b0;
      r_ready    <= 1'b0;
      r_error    <= 1'b0;
      r_rdata    <= '0;
      r_req_data <= '0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.reg_valid_i) begin
            r_req_data <= w_req_pack;
            r_req      <= 1'b1;
            r_state    <= S_REQ_HI;
          end
        end
        S_REQ_HI: begin
          if (w_ack_s) begin
            r_req   <= 1'b0;
            r_state <= S_REQ_LO;
          end
        end
        S_REQ_LO: begin
          if (!w_ack_s) begin
            r_state <= S_RSP_WAIT;
          end
        end
        S_RSP_WAIT: begin
          if (w_rreq_s) begin
            r_rdata   <= w_rsp_rdata;
            r_error   <= w_rsp_error;
            r_ready   <= 1'b1;
            r_rsp_ack <= 1'b1;
            r_state   <= S_RSP_LO;
          end
        end
        S_RSP_LO: begin
          if (!w_rreq_s) begin
            r_rsp_ack <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_req     <= 1'b0;
          r_rsp_ack <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.async_reg_req_req_o  = r_req;
  assign bus.async_reg_req_data_o = r_req_data;
  assign bus.async_reg_rsp_ack_o  = r_rsp_ack;
  assign bus.reg_ready_o          = r_ready;
  assign bus.reg_rdata_o          = r_rdata;
  assign bus.reg_error_o          = r_error;

  // A response req outside the response phase is a peer protocol violation; it is ignored.
  a_no_stray_rsp: assert property (
    @(posedge clk_sys_i) disable iff (!rst_sys_ni)
    w_rreq_s |-> (r_state == S_RSP_WAIT || r_state == S_RSP_LO)
  );

endmodule
`default_nettype wire

// File: tb/tb_hyperbus_reg_async_src.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_hyperbus_reg_async_src
//  Brief    : Scoreboard bench for the HyperBus register crossing source,
//             with a behavioural HyperBus-side register peer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hyperbus_reg_async_src;

  localparam int SYNC = 3;
  localparam int TMO  = 5000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hyperbus_reg_async_src_if #(.RegAddrWidth(32), .RegDataWidth(32)) bus ();

  hyperbus_reg_async_src #(
    .RegAddrWidth (32),
    .RegDataWidth (32),
    .SyncStages   (SYNC)
  ) dut (
    .clk_sys_i  (clk),
    .rst_sys_ni (rst_n),
    .bus        (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input bit ok,
                       input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- reference rules ----------------
  function automatic logic [31:0] dflt_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] ws);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (ws[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  function automatic bit is_err(input logic [31:0] a);
    return a[31:24] == 8'hEE;
  endfunction

  logic [31:0] mem_ref [logic [31:0]];
  logic [31:0] mem_far [logic [31:0]];
  logic [69:0] exp_req_q [$];
  logic [32:0] exp_rsp_q [$];

  // ---------------- HyperBus-side peer ----------------
  int unsigned far_base = 0;
  int unsigned far_jit  = 0;
  int          fs       = 0;
  int          f_cnt    = -1;
  logic [69:0] f_cap, f_first, f_e;
  logic [33:0] f_rsp;

  function automatic int pick();
    return int'(far_base + $urandom_range(0, far_jit));
  endfunction

  // Behavioural peer: acks requests after a jittered delay, answers from its own register array.
  always @(posedge clk) begin : far_p
    logic [31:0] fa, fwd, frd, k, old;
    logic        fw, fer;
    logic [3:0]  fws;
    if (!rst_n) begin
      fs <= 0; f_cnt <= -1;
      bus.async_reg_req_ack_i  <= 1'b0;
      bus.async_reg_rsp_req_i  <= 1'b0;
      bus.async_reg_rsp_data_i <= '0;
    end else begin
      case (fs)
        0: if (bus.async_reg_req_req_o) begin
          if (f_cnt < 0) begin
            f_cnt <= pick(); f_first <= bus.async_reg_req_data_o;
          end else if (f_cnt > 0) begin
            f_cnt <= f_cnt - 1;
            check("req_payload_stable_pre_ack", bus.async_reg_req_data_o === f_first,
                  bus.async_reg_req_data_o, f_first);
          end else begin
            f_cap <= bus.async_reg_req_data_o;
            bus.async_reg_req_ack_i <= 1'b1;
            fs <= 1; f_cnt <= -1;
            if (exp_req_q.size() == 0) begin
              check("req_unexpected", 1'b0, bus.async_reg_req_data_o, 0);
            end else begin
              f_e = exp_req_q.pop_front();
              check("req_payload", bus.async_reg_req_data_o === f_e, bus.async_reg_req_data_o, f_e);
            end
            fa = bus.async_reg_req_data_o[69:38]; fw = bus.async_reg_req_data_o[37];
            fwd = bus.async_reg_req_data_o[36:5]; fws = bus.async_reg_req_data_o[4:1];
            if (is_err(fa)) begin
              frd = ~fa; fer = 1'b1;
            end else begin
              k = {fa[31:2], 2'b00};
              old = mem_far.exists(k) ? mem_far[k] : dflt_word(fa);
              fer = 1'b0;
              if (fw) begin mem_far[k] = merge(old, fwd, fws); frd = '0; end
              else frd = old;
            end
            f_rsp <= {frd, fer, 1'($urandom_range(0, 1))};
          end
        end
        1: if (bus.async_reg_req_req_o) begin
          check("req_payload_stable_post_ack", bus.async_reg_req_data_o === f_cap,
                bus.async_reg_req_data_o, f_cap);
        end else if (f_cnt < 0) f_cnt <= pick();
        else if (f_cnt > 0) f_cnt <= f_cnt - 1;
        else begin bus.async_reg_req_ack_i <= 1'b0; fs <= 2; f_cnt <= -1; end
        2: if (f_cnt < 0) f_cnt <= pick() + 1;
        else if (f_cnt > 0) f_cnt <= f_cnt - 1;
        else begin
          bus.async_reg_rsp_data_i <= f_rsp; bus.async_reg_rsp_req_i <= 1'b1;
          fs <= 3; f_cnt <= -1;
        end
        3: if (bus.async_reg_rsp_ack_o) begin
          if (f_cnt < 0) f_cnt <= pick();
          else if (f_cnt > 0) f_cnt <= f_cnt - 1;
          else begin bus.async_reg_rsp_req_i <= 1'b0; fs <= 4; f_cnt <= -1; end
        end
        default: if (!bus.async_reg_rsp_ack_o) begin fs <= 0; f_cnt <= -1; end
      endcase
    end
  end

  // ---------------- monitor ----------------
  int n_ready = 0, req_rise = 0, req_fall = 0, ack_rise = 0, ack_fall = 0;
  int rrq_rise = 0, rrq_fall = 0, rak_rise = 0, rak_fall = 0, ack_low_run = 0;
  logic p_req = 0, p_ack = 0, p_rrq = 0, p_rak = 0;
  logic [32:0] m_e;

  // Pop the scoreboard on every ready pulse and count handshake edges.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.reg_ready_o) begin
        n_ready++;
        if (exp_rsp_q.size() == 0) begin
          check("ready_spurious", 1'b0, 1, 0);
        end else begin
          m_e = exp_rsp_q.pop_front();
          check("rsp_rdata", bus.reg_rdata_o === m_e[32:1], bus.reg_rdata_o, m_e[32:1]);
          check("rsp_error", bus.reg_error_o === m_e[0], bus.reg_error_o, m_e[0]);
        end
      end
      if (bus.async_reg_req_req_o && !p_req) begin
        req_rise++;
        check("req_rise_with_ack_low", ack_low_run >= SYNC, ack_low_run, SYNC);
      end
      if (!bus.async_reg_req_req_o && p_req) req_fall++;
      if (bus.async_reg_req_ack_i && !p_ack) ack_rise++;
      if (!bus.async_reg_req_ack_i && p_ack) ack_fall++;
      if (bus.async_reg_rsp_req_i && !p_rrq) rrq_rise++;
      if (!bus.async_reg_rsp_req_i && p_rrq) rrq_fall++;
      if (bus.async_reg_rsp_ack_o && !p_rak) rak_rise++;
      if (!bus.async_reg_rsp_ack_o && p_rak) rak_fall++;
    end
    ack_low_run = bus.async_reg_req_ack_i ? 0 : ack_low_run + 1;
    p_req = bus.async_reg_req_req_o; p_ack = bus.async_reg_req_ack_i;
    p_rrq = bus.async_reg_rsp_req_i; p_rak = bus.async_reg_rsp_ack_o;
  end

  // ---------------- driver ----------------
  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input bit hold, input bit chk_lat);
    logic [31:0] rd, k, old;
    bit er;
    int c = 0;
    if (is_err(a)) begin
      rd = ~a; er = 1'b1;
    end else begin
      k = {a[31:2], 2'b00};
      old = mem_ref.exists(k) ? mem_ref[k] : dflt_word(a);
      er = 1'b0;
      if (wr) begin mem_ref[k] = merge(old, wd, ws); rd = '0; end
      else rd = old;
    end
    exp_req_q.push_back({a, wr, wd, ws, 1'b1});
    exp_rsp_q.push_back({rd, er});
    bus.reg_valid_i = 1'b1; bus.reg_write_i = wr; bus.reg_addr_i = a;
    bus.reg_wdata_i = wd; bus.reg_wstrb_i = ws;
    if (chk_lat) begin
      @(negedge clk);
      check("req_latency_1cycle", bus.async_reg_req_req_o === 1'b1, bus.async_reg_req_req_o, 1);
    end
    do begin @(negedge clk); c++; end while (bus.reg_ready_o !== 1'b1 && c < TMO);
    if (c >= TMO) check("ready_timeout", 1'b0, c, TMO);
    if (!hold) bus.reg_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((bus.async_reg_rsp_ack_o !== 1'b0 || bus.async_reg_req_req_o !== 1'b0) && c < TMO) begin
      @(negedge clk); c++;
    end
    if (c >= TMO) check("idle_timeout", 1'b0, c, TMO);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_addr();
    if ($urandom_range(0, 7) == 0) return {8'hEE, 16'h0, 6'($urandom), 2'b00};
    return {27'h0, 3'($urandom), 2'b00};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_rr, s_rf, s_ar, s_af, s_qr, s_qf, s_kr, s_kf, s_rd, c;
    bit hold;
    bus.reg_valid_i = 0; bus.reg_write_i = 0; bus.reg_addr_i = '0;
    bus.reg_wdata_i = '0; bus.reg_wstrb_i = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.reg_ready_o === 1'b0, bus.reg_ready_o, 0);
    check("rst_rdata", bus.reg_rdata_o === '0, bus.reg_rdata_o, 0);
    check("rst_error", bus.reg_error_o === 1'b0, bus.reg_error_o, 0);
    check("rst_req", bus.async_reg_req_req_o === 1'b0, bus.async_reg_req_req_o, 0);
    check("rst_req_data", bus.async_reg_req_data_o === '0, bus.async_reg_req_data_o, 0);
    check("rst_rsp_ack", bus.async_reg_rsp_ack_o === 1'b0, bus.async_reg_rsp_ack_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed write, read-back, error
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1);
    wait_idle();
    check("write_ready_once", n_ready == 1, n_ready, 1);
    issue(1'b1, 32'h20, 32'h12345678, 4'hF, 1'b0, 1'b1);
    wait_idle();
    issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 1'b1);
    wait_idle();
    check("read_rdata_held", bus.reg_rdata_o === 32'h12345678, bus.reg_rdata_o, 32'h12345678);
    issue(1'b0, 32'hEE000004, 32'h0, 4'h0, 1'b0, 1'b1);
    wait_idle();
    check("error_flag_held", bus.reg_error_o === 1'b1, bus.reg_error_o, 1);
    issue(1'b1, 32'h14, 32'hA5A5_0F0F, 4'h5, 1'b0, 1'b1);
    wait_idle();

    // Back-to-back writes with valid held high
    s_rr = req_rise; s_rf = req_fall; s_ar = ack_rise; s_af = ack_fall;
    s_qr = rrq_rise; s_qf = rrq_fall; s_kr = rak_rise; s_kf = rak_fall; s_rd = n_ready;
    for (int i = 0; i < 8; i++)
      issue(1'b1, {27'h0, 3'(i), 2'b00}, $urandom, 4'($urandom), i < 7, 1'b0);
    wait_idle();
    check("b2b_ready", n_ready - s_rd == 8, n_ready - s_rd, 8);
    check("b2b_req_rise", req_rise - s_rr == 8, req_rise - s_rr, 8);
    check("b2b_req_fall", req_fall - s_rf == 8, req_fall - s_rf, 8);
    check("b2b_ack_cycles", (ack_rise - s_ar == 8) && (ack_fall - s_af == 8), ack_fall - s_af, 8);
    check("b2b_rsp_req_cycles", (rrq_rise - s_qr == 8) && (rrq_fall - s_qf == 8), rrq_fall - s_qf, 8);
    check("b2b_rsp_ack_cycles", (rak_rise - s_kr == 8) && (rak_fall - s_kf == 8), rak_fall - s_kf, 8);

    // Reset while in REQ_HI
    far_base = 20; far_jit = 0;
    bus.reg_valid_i = 1'b1; bus.reg_write_i = 1'b0; bus.reg_addr_i = 32'h20;
    c = 0;
    while (bus.async_reg_req_req_o !== 1'b1 && c < 100) begin @(negedge clk); c++; end
    check("reset_test_reached_req_hi", bus.async_reg_req_req_o === 1'b1, bus.async_reg_req_req_o, 1);
    rst_n = 1'b0; bus.reg_valid_i = 1'b0;
    @(negedge clk);
    check("midrst_outputs_zero",
          {bus.reg_ready_o, bus.reg_rdata_o, bus.reg_error_o, bus.async_reg_req_req_o,
           bus.async_reg_req_data_o, bus.async_reg_rsp_ack_o} === '0,
          {bus.reg_rdata_o, bus.async_reg_req_req_o, bus.async_reg_rsp_ack_o}, 0);
    repeat (2) @(negedge clk);
    exp_req_q.delete(); exp_rsp_q.delete();
    far_base = 0;
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b1, 32'h40, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b1);
    wait_idle();
    issue(1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b1);
    wait_idle();

    // Slow, jittery far side
    far_base = 50; far_jit = 8;
    s_rd = n_ready;
    for (int i = 0; i < 4; i++) begin
      issue(1'($urandom), rnd_addr(), $urandom, 4'($urandom), 1'b0, 1'b0);
      wait_idle();
    end
    check("slow_ready_count", n_ready - s_rd == 4, n_ready - s_rd, 4);

    // Random traffic
    far_base = 0; far_jit = 3;
    for (int i = 0; i < 40; i++) begin
      hold = (i < 39) && ($urandom_range(0, 1) == 1);
      issue(1'($urandom), rnd_addr(), $urandom, 4'($urandom), hold, 1'b0);
      if (!hold) wait_idle();
    end
    wait_idle();

    check("scoreboard_rsp_drained", exp_rsp_q.size() == 0, exp_rsp_q.size(), 0);
    check("scoreboard_req_drained", exp_req_q.size() == 0, exp_req_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
